// File: rtl/regfile_wb_pkg.sv
// Shared types and sizes for the register-file writeback path.
package regfile_wb_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Writeback FIFO: up to two pushes (din0 first, then din1) and one pop per cycle.
// The head entry is visible combinationally from the storage registers.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push0,
  input  logic       push1,
  input  logic       pop,
  input  wb_entry_t  din0,
  input  wb_entry_t  din1,
  output wb_entry_t  head,
  output logic [AW:0] free,
  output logic       full,
  output logic       empty
);
  wb_entry_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr, wr_ptr1;
  logic [AW:0]    count;
  logic           pop_ok;

  assign wr_ptr1 = wr_ptr + 1'b1;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr]  <= din0;
    if (push1) mem[wr_ptr1] <= din1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
      rd_ptr <= rd_ptr + AW'(pop_ok);
      count  <= count + (AW+1)'(push0) + (AW+1)'(push1) - (AW+1)'(pop_ok);
    end
  end

  assign head  = mem[rd_ptr];
  assign free  = (AW+1)'(DEPTH) - count;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/regfile_writeback.sv
// Register-file write initiator: arbitrates ALU/load results into a FIFO, drains one
// write per cycle and tracks pending writes per register. Optional WB_BYPASS_EN adds forwarding.
module regfile_writeback
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNTW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [4:0]        alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [4:0]        mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  output logic              mem_ready,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rd,
  output logic              issue_ready,
  input  logic [4:0]        chk_rs1,
  input  logic [4:0]        chk_rs2,
  output logic              busy1,
  output logic              busy2,
  output logic              rf_we,
  output logic [4:0]        rf_addr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              fifo_full,
  output logic              fifo_empty
`ifdef WB_BYPASS_EN
  ,
  output logic              fwd1_valid,
  output logic              fwd2_valid,
  output logic [XLEN-1:0]   fwd1_data,
  output logic [XLEN-1:0]   fwd2_data
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  wb_entry_t   head, din0, din1, last;
  logic [AW:0] free;
  logic [AW+1:0] room, need_alu;
  logic        mem_nz, alu_nz, mem_push, alu_push;

  // Room counts the slot vacated by this cycle's drain.
  assign room     = {1'b0, free} + (AW+2)'(rf_we);
  assign mem_nz   = (mem_rd != '0);
  assign alu_nz   = (alu_rd != '0);
  assign need_alu = (mem_valid && mem_nz) ? (AW+2)'(2) : (AW+2)'(1);

  assign mem_ready = !mem_nz || (room != '0);
  assign alu_ready = !alu_nz || (room >= need_alu);
  assign mem_push  = mem_valid && mem_nz && (room != '0);
  assign alu_push  = alu_valid && alu_nz && (room >= need_alu);

  assign din0 = mem_push ? '{rd: mem_rd, data: mem_data} : '{rd: alu_rd, data: alu_data};
  assign din1 = '{rd: alu_rd, data: alu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push0 (mem_push || alu_push),
    .push1 (mem_push && alu_push),
    .pop   (rf_we),
    .din0  (din0),
    .din1  (din1),
    .head  (head),
    .free  (free),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Address/data hold the last written entry once the FIFO runs dry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     last <= '0;
    else if (rf_we) last <= head;
  end

  assign rf_we    = !fifo_empty;
  assign rf_addr  = fifo_empty ? last.rd   : head.rd;
  assign rf_wdata = fifo_empty ? last.data : head.data;

  logic [NREGS-1:0][CNTW-1:0] cnt;
  logic [NREGS-1:0]           inc_vec, dec_vec;
  logic                       issue_fire;

  assign issue_ready = (cnt[issue_rd] != CNT_MAX);
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);
  assign inc_vec[0]  = 1'b0;
  assign dec_vec[0]  = 1'b0;

  for (genvar gi = 1; gi < NREGS; gi++) begin : g_sb
    assign inc_vec[gi] = issue_fire && (issue_rd == REG_AW'(gi));
    assign dec_vec[gi] = rf_we && (rf_addr == REG_AW'(gi)) && (cnt[gi] != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (inc_vec[i] && !dec_vec[i])      cnt[i] <= cnt[i] + 1'b1;
        else if (dec_vec[i] && !inc_vec[i]) cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd1_valid = rf_we && (rf_addr == chk_rs1) && (chk_rs1 != '0) && (cnt[chk_rs1] == CNTW'(1));
  assign fwd2_valid = rf_we && (rf_addr == chk_rs2) && (chk_rs2 != '0) && (cnt[chk_rs2] == CNTW'(1));
  assign fwd1_data  = rf_wdata;
  assign fwd2_data  = rf_wdata;
  assign busy1 = (cnt[chk_rs1] != '0) && !fwd1_valid;
  assign busy2 = (cnt[chk_rs2] != '0) && !fwd2_valid;
`else
  assign busy1 = (cnt[chk_rs1] != '0);
  assign busy2 = (cnt[chk_rs2] != '0);
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: accepted results are queued as expected writes
// and a negedge monitor compares each register-file write against the queue head.
module tb_regfile_writeback;
  import regfile_wb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;
  logic alu_valid = 0, mem_valid = 0, issue_valid = 0;
  logic [4:0] alu_rd = 0, mem_rd = 0, issue_rd = 0, chk_rs1 = 0, chk_rs2 = 0;
  logic [31:0] alu_data = 0, mem_data = 0;
  logic alu_ready, mem_ready, issue_ready, busy1, busy2, rf_we, fifo_full, fifo_empty;
  logic [4:0] rf_addr;
  logic [31:0] rf_wdata;
`ifdef WB_BYPASS_EN
  logic fwd1_valid, fwd2_valid;
  logic [31:0] fwd1_data, fwd2_data;
`endif

  regfile_writeback dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .busy1(busy1), .busy2(busy2),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty)
`ifdef WB_BYPASS_EN
    , .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
`endif
  );

  typedef struct { logic [4:0] rd; logic [31:0] data; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int tests = 0, fails = 0;
  logic [31:0] model_rf [32];
  logic last_mem_acc, last_alu_acc, last_mem_ready, last_alu_ready;
  logic saw_full = 0, alu_ready_when_full = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Present one cycle of results, record what will be accepted, return at next negedge.
  task automatic drive(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad);
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    #1;
    last_mem_ready = mem_ready;
    last_alu_ready = alu_ready;
    last_mem_acc = mv && mem_ready;
    last_alu_acc = av && alu_ready;
    if (last_mem_acc && mrd != 0) exp_q.push_back('{mrd, md});
    if (last_alu_acc && ard != 0) exp_q.push_back('{ard, ad});
    if (fifo_full) saw_full = 1;
    if (fifo_full && mv && mrd != 0 && av && ard != 0) alu_ready_when_full |= alu_ready;
    @(negedge clk);
    mem_valid = 0; alu_valid = 0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset && rf_we) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write: got x%0d=%h, expected no write", rf_addr, rf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        $display("[TB] write x%0d = %h (expected x%0d = %h)", rf_addr, rf_wdata, mon_e.rd, mon_e.data);
        check("wb_addr", {27'd0, rf_addr}, {27'd0, mon_e.rd});
        check("wb_data", rf_wdata, mon_e.data);
        model_rf[rf_addr] = rf_wdata;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) model_rf[i] = 0;
    chk_rs1 = 5; chk_rs2 = 7;
    #1;
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_addr", rf_addr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_fifo_empty", fifo_empty, 1);
    check("rst_fifo_full", fifo_full, 0);
    check("rst_busy1", busy1, 0);
    check("rst_busy2", busy2, 0);
    @(negedge clk); @(negedge clk);
    reset = 1;
    @(negedge clk);

    // Single ALU result: visible for exactly one cycle after acceptance.
    drive(0, 0, 0, 1, 5, 32'hDEADBEEF);
    check("lat_rf_we", rf_we, 1);
    check("lat_rf_addr", rf_addr, 5);
    check("lat_rf_wdata", rf_wdata, 32'hDEADBEEF);
    @(negedge clk);
    check("lat_we_low", rf_we, 0);
    check("lat_empty", fifo_empty, 1);
    check("lat_addr_hold", rf_addr, 5);

    // Same-cycle mem and alu to the same register: mem first, alu wins.
    drive(1, 3, 32'h11, 1, 3, 32'h22);
    check("both_first", rf_wdata, 32'h11);
    @(negedge clk);
    check("both_second", rf_wdata, 32'h22);
    wait_drain();
    check("final_x3", model_rf[3], 32'h22);

    // Pending-write scoreboard saturates at three.
    chk_rs1 = 7; chk_rs2 = 3;
    for (int k = 0; k < 3; k++) begin
      issue_valid = 1; issue_rd = 7;
      #1 check("issue_ready_ok", issue_ready, 1);
      @(negedge clk);
    end
    #1 check("issue_ready_max", issue_ready, 0);
    issue_valid = 0;
    check("busy1_pending", busy1, 1);
    check("busy2_idle", busy2, 0);
    drive(0, 0, 0, 1, 7, 32'h1);
    drive(0, 0, 0, 1, 7, 32'h2);
    drive(0, 0, 0, 1, 7, 32'h3);
`ifdef WB_BYPASS_EN
    check("fwd1_valid", fwd1_valid, 1);
    check("fwd1_data", fwd1_data, 32'h3);
    check("busy1_fwd", busy1, 0);
`else
    check("busy1_last_write", busy1, 1);
`endif
    @(negedge clk);
    check("busy1_cleared", busy1, 0);
    #1 check("issue_ready_again", issue_ready, 1);

    // rd==0 results on an empty FIFO.
    chk_rs1 = 0; chk_rs2 = 0;
    drive(1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF);
    check("rd0_mem_ready", last_mem_ready, 1);
    check("rd0_alu_ready", last_alu_ready, 1);
    check("rd0_busy1", busy1, 0);
    check("rd0_busy2", busy2, 0);
    check("rd0_no_we", rf_we, 0);

    // Fill: two retrying streams against a one-per-cycle drain.
    begin
      int mi, ai;
      mi = 0; ai = 0;
      for (int c = 0; c < 100 && (mi < 10 || ai < 10); c++) begin
        drive(mi < 10, 5'(mi + 1), 32'hA000_0000 + mi, ai < 10, 5'(ai + 11), 32'hB000_0000 + ai);
        if (last_mem_acc) mi++;
        if (last_alu_acc) ai++;
      end
      check("fill_all_accepted", mi + ai, 20);
    end
    check("fill_saw_full", saw_full, 1);
    check("fill_alu_blocked", alu_ready_when_full, 0);
    check("full_before_rd0", fifo_full, 1);
    drive(1, 21, 32'hC000_0015, 1, 0, 32'hFFFFFFFF);
    check("full_rd0_alu_ready", last_alu_ready, 1);
    check("full_mem_ready_pop", last_mem_ready, 1);
    wait_drain();
    check("fill_empty_after", fifo_empty, 1);

    // Asynchronous reset with queued writes and pending counters.
    chk_rs1 = 9; chk_rs2 = 10;
    issue_valid = 1; issue_rd = 9;
    @(negedge clk);
    issue_rd = 10;
    @(negedge clk);
    issue_valid = 0;
    drive(1, 11, 32'h1111, 1, 12, 32'h1212);
    drive(1, 13, 32'h1313, 1, 14, 32'h1414);
    check("pre_rst_not_empty", fifo_empty, 0);
    check("pre_rst_busy1", busy1, 1);
    check("pre_rst_busy2", busy2, 1);
    #2 reset = 0;
    #1;
    exp_q.delete();
    check("arst_rf_we", rf_we, 0);
    check("arst_rf_addr", rf_addr, 0);
    check("arst_rf_wdata", rf_wdata, 0);
    check("arst_fifo_empty", fifo_empty, 1);
    check("arst_fifo_full", fifo_full, 0);
    check("arst_busy1", busy1, 0);
    check("arst_busy2", busy2, 0);
    @(negedge clk); @(negedge clk);
    reset = 1;
    repeat (8) @(negedge clk);
    check("post_rst_no_we", rf_we, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
